// File: rtl/repvgg_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : repvgg_acc_pkg
// Description : Shared widths, FSM state encoding and the saturating clip
//               helper used by the RepVGG branch accumulator.
// Revision    : 1.0 - initial parametrised, handshaked release
// ============================================================================
package repvgg_acc_pkg;

    // Default widths of the accumulator slice
    localparam int DW_DEF = 32;   // input partial-sum width
    localparam int AW_DEF = 40;   // accumulator width
    localparam int OW_DEF = 32;   // saturated output width
    localparam int DP_DEF = 56;   // lanes per row
    localparam int KR_DEF = 3;    // 3x3-branch row partials per beat
    localparam int TW_DEF = 8;    // tile-counter width

    // Working width of the clip helper; AW must not exceed it, OW must be below it
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } acc_state_e;

    typedef struct packed {
        logic [SAT_W-1:0] value;
        logic             sat;
    } sat_res_t;

    // Clamp a sign-extended accumulator value to the signed range of an
    // ow-bit result. The low ow bits of .value carry the clipped result.
    function automatic sat_res_t sat_clip(input logic signed [SAT_W-1:0] a,
                                          input int unsigned             ow);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                r;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (a > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (a < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end else begin
            r.value = a;
            r.sat   = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/repvgg_lane_acc.sv
`default_nettype none
// ============================================================================
// Module      : repvgg_lane_acc
// Description : One output lane: (KR+2)-input branch adder, stage-1 register,
//               tile accumulator and saturating output register.
// Ports       : clk, rst_n      - clock, async active-low reset
//               s1_load_i       - accepted beat: capture lane sum in stage 1
//               s1_valid_i      - stage 1 holds a sum to accumulate this cycle
//               s1_first_i      - stage-1 sum is the first tile of its group
//               en_c1_i/en_id_i - include 1x1 / identity branch in the sum
//               out_load_i      - load saturated accumulator into output reg
//               conv3_i         - KR row partials, row r at [DW*r +: DW]
//               conv1_i, ori_i  - 1x1 and identity partials
//               data_o, sat_o   - saturated result and clamp flag
// Revision    : 1.0 - initial release
// ============================================================================
module repvgg_lane_acc
    import repvgg_acc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int OW = OW_DEF,
    parameter int KR = KR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1_load_i,
    input  logic              s1_valid_i,
    input  logic              s1_first_i,
    input  logic              en_c1_i,
    input  logic              en_id_i,
    input  logic              out_load_i,
    input  logic [KR*DW-1:0]  conv3_i,
    input  logic [DW-1:0]     conv1_i,
    input  logic [DW-1:0]     ori_i,
    output logic [OW-1:0]     data_o,
    output logic              sat_o
);

    logic signed [AW-1:0] s1_d;
    logic signed [AW-1:0] s1_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_q;
    logic [OW-1:0]        data_q;
    logic                 sat_q;
    sat_res_t             w_clip;
    logic                 w_unused_clip;

    // Branch merge: every operand sign-extended to AW before summing
    always_comb begin
        s1_d = '0;
        for (int r = 0; r < KR; r++) begin
            s1_d = s1_d + AW'($signed(conv3_i[DW*r +: DW]));
        end
        if (en_c1_i) begin
            s1_d = s1_d + AW'($signed(conv1_i));
        end
        if (en_id_i) begin
            s1_d = s1_d + AW'($signed(ori_i));
        end
    end

    // First tile overwrites, so no separate clear cycle is needed between groups
    always_comb begin
        acc_d = acc_q;
        if (s1_valid_i) begin
            acc_d = s1_first_i ? s1_q : (acc_q + s1_q);
        end
    end

    assign w_clip        = sat_clip(SAT_W'(acc_q), OW);
    assign w_unused_clip = ^w_clip.value[SAT_W-1:OW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            acc_q  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (s1_load_i) begin
                s1_q <= s1_d;
            end
            acc_q <= acc_d;
            if (out_load_i) begin
                data_q <= w_clip.value[OW-1:0];
                sat_q  <= w_clip.sat;
            end
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;

endmodule
`default_nettype wire

// File: rtl/repvgg_branch_acc.sv
`default_nettype none
// ============================================================================
// Module      : repvgg_branch_acc
// Description : RepVGG branch accumulator. Merges 3x3 row partials, the 1x1
//               branch and the identity branch per lane, accumulates over a
//               runtime number of input-channel tiles and emits one saturated
//               row per group over a valid/ready handshake.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               clr_i                       - synchronous abort of the group
//               cfg_tiles_i/en_c1_i/en_id_i - group config, taken on 1st beat
//               in_valid_i/in_ready_o       - input beat handshake
//               in_conv3_i                  - row r lane i at [DW*(r*DP+i)]
//               in_conv1_i, in_ori_i        - lane i at [DW*i]
//               out_valid_o/out_ready_i     - output row handshake
//               out_data_o                  - lane i at [OW*i]
//               out_sat_o                   - per-lane saturation flag
// Revision    : 1.0 - initial parametrised, handshaked release
// ============================================================================
module repvgg_branch_acc
    import repvgg_acc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int OW = OW_DEF,
    parameter int DP = DP_DEF,
    parameter int KR = KR_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic [TW-1:0]       cfg_tiles_i,
    input  logic                cfg_en_c1_i,
    input  logic                cfg_en_id_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [KR*DP*DW-1:0] in_conv3_i,
    input  logic [DP*DW-1:0]    in_conv1_i,
    input  logic [DP*DW-1:0]    in_ori_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DP*OW-1:0]    out_data_o,
    output logic [DP-1:0]       out_sat_o
);

    acc_state_e    state_q,     state_d;
    logic [TW-1:0] tile_cnt_q,  tile_cnt_d;
    logic [TW-1:0] tiles_q,     tiles_d;
    logic          en_c1_q,     en_c1_d;
    logic          en_id_q,     en_id_d;
    logic          s1_valid_q,  s1_valid_d;
    logic          s1_first_q,  s1_first_d;

    logic          w_accept;
    logic          w_first;
    logic [TW-1:0] w_tiles_eff;
    logic          w_en_c1;
    logic          w_en_id;
    logic [TW:0]   w_cnt_inc;
    logic          w_last;
    logic          w_out_load;

    assign in_ready_o  = (state_q == ST_ACC);
    assign out_valid_o = (state_q == ST_OUT);

    assign w_accept = in_ready_o && in_valid_i && !clr_i;
    assign w_first  = (tile_cnt_q == '0);

    // The first beat of a group uses the live config; later beats the latched copy
    assign w_tiles_eff = w_first ? ((cfg_tiles_i == '0) ? TW'(1) : cfg_tiles_i)
                                 : tiles_q;
    assign w_en_c1     = w_first ? cfg_en_c1_i : en_c1_q;
    assign w_en_id     = w_first ? cfg_en_id_i : en_id_q;

    assign w_cnt_inc = {1'b0, tile_cnt_q} + (TW+1)'(1);
    assign w_last    = (w_cnt_inc == {1'b0, w_tiles_eff});

    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        tiles_d    = tiles_q;
        en_c1_d    = en_c1_q;
        en_id_d    = en_id_q;
        s1_valid_d = 1'b0;
        s1_first_d = s1_first_q;
        w_out_load = 1'b0;
        if (clr_i) begin
            state_d    = ST_ACC;
            tile_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (w_accept) begin
                        s1_valid_d = 1'b1;
                        s1_first_d = w_first;
                        tiles_d    = w_tiles_eff;
                        en_c1_d    = w_en_c1;
                        en_id_d    = w_en_id;
                        if (w_last) begin
                            tile_cnt_d = '0;
                            state_d    = ST_DRAIN;
                        end else begin
                            tile_cnt_d = w_cnt_inc[TW-1:0];
                        end
                    end
                end
                // Stay until the final stage-1 sum has been folded into the
                // accumulator, then capture the clipped result.
                ST_DRAIN: begin
                    if (!s1_valid_q) begin
                        w_out_load = 1'b1;
                        state_d    = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        state_d = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            tile_cnt_q <= '0;
            tiles_q    <= '0;
            en_c1_q    <= 1'b0;
            en_id_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
            tiles_q    <= tiles_d;
            en_c1_q    <= en_c1_d;
            en_id_q    <= en_id_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
        end
    end

    for (genvar i = 0; i < DP; i++) begin : g_lane
        logic [KR*DW-1:0] w_c3;

        for (genvar r = 0; r < KR; r++) begin : g_row
            assign w_c3[DW*r +: DW] = in_conv3_i[DW*(r*DP+i) +: DW];
        end

        repvgg_lane_acc #(
            .DW (DW),
            .AW (AW),
            .OW (OW),
            .KR (KR)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .s1_load_i  (w_accept),
            .s1_valid_i (s1_valid_q),
            .s1_first_i (s1_first_q),
            .en_c1_i    (w_en_c1),
            .en_id_i    (w_en_id),
            .out_load_i (w_out_load),
            .conv3_i    (w_c3),
            .conv1_i    (in_conv1_i[DW*i +: DW]),
            .ori_i      (in_ori_i[DW*i +: DW]),
            .data_o     (out_data_o[OW*i +: OW]),
            .sat_o      (out_sat_o[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_repvgg_branch_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_repvgg_branch_acc
// Description : Directed self-checking bench for repvgg_branch_acc with
//               hand-computed expected rows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_repvgg_branch_acc;

    localparam int DP = 56;
    localparam int DW = 32;
    localparam int OW = 32;
    localparam int KR = 3;
    localparam int TW = 8;

    logic                clk;
    logic                rst_n;
    logic                clr;
    logic [TW-1:0]       cfg_tiles;
    logic                cfg_en_c1;
    logic                cfg_en_id;
    logic                in_valid;
    logic                in_ready;
    logic [KR*DP*DW-1:0] in_conv3;
    logic [DP*DW-1:0]    in_conv1;
    logic [DP*DW-1:0]    in_ori;
    logic                out_valid;
    logic                out_ready;
    logic [DP*OW-1:0]    out_data;
    logic [DP-1:0]       out_sat;

    int n_checks = 0;
    int n_err    = 0;

    repvgg_branch_acc u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .cfg_tiles_i (cfg_tiles),
        .cfg_en_c1_i (cfg_en_c1),
        .cfg_en_id_i (cfg_en_id),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_conv3_i  (in_conv3),
        .in_conv1_i  (in_conv1),
        .in_ori_i    (in_ori),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sat_o   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] c1, input logic [31:0] ori);
        for (int i = 0; i < DP; i++) begin
            in_conv3[DW*(0*DP+i) +: DW] = r0;
            in_conv3[DW*(1*DP+i) +: DW] = r1;
            in_conv3[DW*(2*DP+i) +: DW] = r2;
            in_conv1[DW*i +: DW]        = c1;
            in_ori[DW*i +: DW]          = ori;
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2);
        in_conv3[DW*(0*DP+i) +: DW] = r0;
        in_conv3[DW*(1*DP+i) +: DW] = r1;
        in_conv3[DW*(2*DP+i) +: DW] = r2;
    endtask

    // Present one beat and return #1 after the edge that accepted it
    task automatic send_beat();
        int t;
        t = 0;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) chk("beat_accept_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] lane_out(input int i);
        logic [DP*OW-1:0] d;
        d = out_data;
        return d[OW*i +: OW];
    endfunction

    initial begin
        logic [31:0] held;
        rst_n     = 1'b0;
        clr       = 1'b0;
        cfg_tiles = '0;
        cfg_en_c1 = 1'b0;
        cfg_en_id = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_conv3  = '0;
        in_conv1  = '0;
        in_ori    = '0;

        // ---------------- reset state ----------------
        #23;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data[63:0], 0);
        chk("rst_out_sat", out_sat, 0);
        rst_n = 1'b1;
        step();

        // ---------------- single tile, all branches ----------------
        cfg_tiles = 8'd1; cfg_en_c1 = 1'b1; cfg_en_id = 1'b1;
        fill(32'd1, 32'd2, 32'd3, 32'd10, 32'd100);
        send_beat();
        chk("t1_valid_n1", out_valid, 0);
        chk("t1_ready_drain", in_ready, 0);
        step();
        chk("t1_valid_n2", out_valid, 0);
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_lane0", lane_out(0), 116);
        chk("t1_lane55", lane_out(55), 116);
        chk("t1_sat", out_sat, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_valid_after_hs", out_valid, 0);
        chk("t1_ready_after_hs", in_ready, 1);

        // ---------------- multi-tile, 1x1 only, mid-group config change ----------------
        cfg_tiles = 8'd4; cfg_en_c1 = 1'b1; cfg_en_id = 1'b0;
        fill(32'd1, 32'd1, 32'd1, 32'd2, 32'd999);
        send_beat();
        cfg_tiles = 8'd1; cfg_en_id = 1'b1;
        send_beat();
        send_beat();
        send_beat();
        // Keep offering a beat through DRAIN and OUT: none may be taken
        fill(32'd7, 32'd7, 32'd7, 32'd7, 32'd7);
        in_valid = 1'b1;
        chk("t2_ready_drain0", in_ready, 0);
        step();
        chk("t2_ready_drain1", in_ready, 0);
        step();
        chk("t2_valid", out_valid, 1);
        chk("t2_ready_out", in_ready, 0);
        chk("t2_lane0", lane_out(0), 20);
        chk("t2_lane31", lane_out(31), 20);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        out_ready = 1'b0;
        chk("t2_ready_after_hs", in_ready, 1);

        // ---------------- saturation + backpressure ----------------
        cfg_tiles = 8'd2; cfg_en_c1 = 1'b0; cfg_en_id = 1'b0;
        fill(32'd0, 32'd0, 32'd0, 32'd5, 32'd5);
        set_lane(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        set_lane(1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        set_lane(2, 32'hFFFF_FFFF, 32'd0, 32'd0);
        send_beat();
        send_beat();
        step();
        step();
        chk("t3_valid", out_valid, 1);
        chk("t3_lane0", lane_out(0), 64'h7FFF_FFFF);
        chk("t3_lane1", lane_out(1), 64'h8000_0000);
        chk("t3_lane2", lane_out(2), 64'hFFFF_FFFE);
        chk("t3_lane3", lane_out(3), 0);
        chk("t3_sat", out_sat[3:0], 4'b0011);
        held = lane_out(0);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_data", lane_out(0), held);
            chk("bp_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_ready_same_cycle", in_ready, 0);
        step();
        out_ready = 1'b0;
        chk("bp_ready_next", in_ready, 1);
        chk("bp_valid_next", out_valid, 0);

        // ---------------- abort mid-group, then cfg_tiles=0 ----------------
        cfg_tiles = 8'd3; cfg_en_c1 = 1'b1; cfg_en_id = 1'b1;
        fill(32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
        send_beat();
        in_valid = 1'b1;
        clr      = 1'b1;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_ready", in_ready, 1);
        chk("clr_valid", out_valid, 0);
        cfg_tiles = 8'd0; cfg_en_c1 = 1'b0; cfg_en_id = 1'b0;
        fill(32'd5, 32'd0, 32'd0, 32'd1, 32'd1);
        send_beat();
        step();
        step();
        chk("t4_valid", out_valid, 1);
        chk("t4_lane0", lane_out(0), 5);
        chk("t4_lane55", lane_out(55), 5);
        // clr together with the output handshake
        out_ready = 1'b1;
        clr       = 1'b1;
        step();
        out_ready = 1'b0;
        clr       = 1'b0;
        chk("clr_hs_valid", out_valid, 0);
        chk("clr_hs_ready", in_ready, 1);
        // clr while draining: no row may be emitted
        fill(32'd8, 32'd0, 32'd0, 32'd0, 32'd0);
        send_beat();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("clr_drain_valid", out_valid, 0);
            chk("clr_drain_ready", in_ready, 1);
            step();
        end

        // ---------------- async reset in DRAIN ----------------
        cfg_tiles = 8'd1; cfg_en_c1 = 1'b1; cfg_en_id = 1'b1;
        fill(32'd9, 32'd9, 32'd9, 32'd9, 32'd9);
        send_beat();
        chk("ar_in_drain", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_data", lane_out(0), 0);
        #1;
        rst_n = 1'b1;
        step();
        cfg_tiles = 8'd2;
        fill(32'd2, 32'd0, 32'd0, 32'd3, 32'd4);
        send_beat();
        send_beat();
        step();
        step();
        chk("ar_next_valid", out_valid, 1);
        chk("ar_next_lane0", lane_out(0), 18);
        chk("ar_next_lane40", lane_out(40), 18);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ar_next_hs", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
